// File: rtl/uart_slot_controller.sv
// rtl/uart_slot_controller.sv - UART slot bus-master sequencer with round-robin tx arbitration and rx holding register
module uart_slot_controller #(
    parameter int          NREQ      = 2,
    parameter logic [13:0] DVSR_INIT = 14'd650
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     tx_valid_i,
    input  logic [8*NREQ-1:0]   tx_data_i,
    output logic [NREQ-1:0]     tx_ready_o,
    output logic                rx_valid_o,
    output logic [7:0]          rx_data_o,
    input  logic                rx_ready_i,
    input  logic                cfg_wr_i,
    input  logic [13:0]         cfg_dvsr_i,
    output logic                cfg_busy_o,
    output logic                slot_cs_o,
    output logic                slot_read_o,
    output logic                slot_write_o,
    output logic [4:0]          slot_addr_o,
    output logic [31:0]         slot_wr_data_o,
    input  logic [31:0]         slot_rd_data_i
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {S_RST, S_CFG, S_POLL, S_TXW, S_RXP} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  rr_ptr_q;
    logic           svc_rx_last_q;
    logic [13:0]    dvsr_q;
    logic           pending_q;
    logic [7:0]     wbyte_q;
    logic           rx_valid_q;
    logic [7:0]     rx_data_q;

    logic           tx_full, rx_empty, rx_ok, tx_ok, in_poll;
    logic           serve_rx, serve_tx, grant_found;
    logic [PW-1:0]  grant_idx, rr_next;
    logic [7:0]     grant_byte;
    int             cand;
    logic           unused_rd_bits;

    assign unused_rd_bits = ^slot_rd_data_i[31:10];
    assign tx_full        = slot_rd_data_i[9];
    assign rx_empty       = slot_rd_data_i[8];

    // A pending reload pre-empts any service decision in POLL.
    assign in_poll  = (state_q == S_POLL) && !pending_q;
    assign rx_ok    = !rx_empty && !rx_valid_q;
    assign tx_ok    = (|tx_valid_i) && !tx_full;
    assign serve_rx = in_poll && rx_ok && (!tx_ok || !svc_rx_last_q);
    assign serve_tx = in_poll && tx_ok && (!rx_ok || svc_rx_last_q);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr_q;
        cand        = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NREQ;
            if (!grant_found && tx_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

    assign grant_byte = tx_data_i[8*grant_idx +: 8];
    assign rr_next    = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    assign tx_ready_o = serve_tx ? (NREQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   state_d = S_CFG;
            S_CFG:   state_d = S_POLL;
            S_POLL: begin
                if (pending_q)     state_d = S_CFG;
                else if (serve_rx) state_d = S_RXP;
                else if (serve_tx) state_d = S_TXW;
            end
            S_TXW:   state_d = S_POLL;
            S_RXP:   state_d = S_POLL;
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_RST;
            rr_ptr_q      <= '0;
            svc_rx_last_q <= 1'b0;
            dvsr_q        <= DVSR_INIT;
            pending_q     <= 1'b0;
            wbyte_q       <= 8'h00;
            rx_valid_q    <= 1'b0;
            rx_data_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == S_CFG)
                pending_q <= 1'b0;
            // A request arriving during CFG survives so the new value is written too.
            if (cfg_wr_i) begin
                dvsr_q    <= cfg_dvsr_i;
                pending_q <= 1'b1;
            end
            if (rx_valid_q && rx_ready_i)
                rx_valid_q <= 1'b0;
            if (serve_rx) begin
                rx_valid_q    <= 1'b1;
                rx_data_q     <= slot_rd_data_i[7:0];
                svc_rx_last_q <= 1'b1;
            end
            if (serve_tx) begin
                wbyte_q       <= grant_byte;
                rr_ptr_q      <= rr_next;
                svc_rx_last_q <= 1'b0;
            end
        end
    end

    always_comb begin
        slot_cs_o      = 1'b0;
        slot_read_o    = 1'b0;
        slot_write_o   = 1'b0;
        slot_addr_o    = 5'd0;
        slot_wr_data_o = 32'd0;
        case (state_q)
            S_CFG: begin
                slot_cs_o      = 1'b1;
                slot_write_o   = 1'b1;
                slot_addr_o    = 5'd1;
                slot_wr_data_o = {18'b0, dvsr_q};
            end
            S_POLL: begin
                slot_cs_o   = 1'b1;
                slot_read_o = 1'b1;
            end
            S_TXW: begin
                slot_cs_o      = 1'b1;
                slot_write_o   = 1'b1;
                slot_addr_o    = 5'd2;
                slot_wr_data_o = {24'b0, wbyte_q};
            end
            S_RXP: begin
                slot_cs_o    = 1'b1;
                slot_write_o = 1'b1;
                slot_addr_o  = 5'd3;
            end
            default: ;
        endcase
    end

    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
    assign cfg_busy_o = pending_q | (state_q == S_CFG);
endmodule

// File: tb/tb_uart_slot_controller.sv
// tb/tb_uart_slot_controller.sv - bench for uart_slot_controller with behavioural slot-access model
module tb_uart_slot_controller;
    localparam int NREQ = 2;
    localparam int OP_NONE = 0, OP_CFG = 1, OP_READ = 2, OP_TXW = 3, OP_POP = 4;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   tx_valid = '0;
    logic [8*NREQ-1:0] tx_data = '0;
    logic [NREQ-1:0]   tx_ready;
    logic              rx_valid, rx_ready = 1'b0;
    logic [7:0]        rx_data;
    logic              cfg_wr = 1'b0, cfg_busy;
    logic [13:0]       cfg_dvsr = '0;
    logic              slot_cs, slot_read, slot_write;
    logic [4:0]        slot_addr;
    logic [31:0]       slot_wr_data;
    logic [31:0]       status = 32'h100;

    uart_slot_controller #(.NREQ(NREQ), .DVSR_INIT(14'd650)) dut (
        .clk(clk), .reset(reset),
        .tx_valid_i(tx_valid), .tx_data_i(tx_data), .tx_ready_o(tx_ready),
        .rx_valid_o(rx_valid), .rx_data_o(rx_data), .rx_ready_i(rx_ready),
        .cfg_wr_i(cfg_wr), .cfg_dvsr_i(cfg_dvsr), .cfg_busy_o(cfg_busy),
        .slot_cs_o(slot_cs), .slot_read_o(slot_read), .slot_write_o(slot_write),
        .slot_addr_o(slot_addr), .slot_wr_data_o(slot_wr_data), .slot_rd_data_i(status)
    );

    int vectors = 0, miscompares = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    int          m_op = OP_NONE, m_rr = 0;
    logic [7:0]  m_wbyte = 8'h00, m_rxd = 8'h00;
    logic [13:0] m_dvsr = 14'd650;
    bit          m_pend = 0, m_rxv = 0, m_lastrx = 0;
    logic [7:0]  sb_q[$];
    logic [NREQ-1:0] last_grant = '0;

    always @(negedge clk) begin : monitor
        bit rxok, txok, srx, stx, n_rxv;
        int g, nop;
        logic [4:0]  e_addr;
        logic [31:0] e_wd;
        logic [NREQ-1:0] e_ready;
        if (reset) begin
            m_op = OP_NONE; m_rr = 0; m_wbyte = 8'h00; m_rxd = 8'h00;
            m_dvsr = 14'd650; m_pend = 0; m_rxv = 0; m_lastrx = 0;
            sb_q.delete();
        end
        srx = 0; stx = 0; g = 0;
        if (m_op == OP_READ && !m_pend) begin
            rxok = !status[8] && !m_rxv;
            txok = (|tx_valid) && !status[9];
            srx  = (rxok && txok) ? !m_lastrx : rxok;
            stx  = txok && !srx;
            for (int k = 0; k < NREQ; k++)
                if (tx_valid[(m_rr + k) % NREQ]) begin g = (m_rr + k) % NREQ; break; end
        end
        e_ready = stx ? NREQ'(1 << g) : '0;
        e_addr  = (m_op == OP_CFG) ? 5'd1 : (m_op == OP_TXW) ? 5'd2 : (m_op == OP_POP) ? 5'd3 : 5'd0;
        e_wd    = (m_op == OP_CFG) ? {18'b0, m_dvsr} : (m_op == OP_TXW) ? {24'b0, m_wbyte} : 32'd0;
        chk("m_cs", slot_cs, m_op != OP_NONE);
        chk("m_read", slot_read, m_op == OP_READ);
        chk("m_write", slot_write, m_op inside {OP_CFG, OP_TXW, OP_POP});
        chk("m_addr", slot_addr, e_addr);
        chk("m_wdata", slot_wr_data, e_wd);
        chk("m_tx_ready", tx_ready, e_ready);
        chk("m_rx_valid", rx_valid, m_rxv);
        chk("m_rx_data", rx_data, m_rxd);
        chk("m_cfg_busy", cfg_busy, m_pend || m_op == OP_CFG);
        if (stx) sb_q.push_back(tx_data[8*g +: 8]);
        if (slot_write && slot_addr == 5'd2) begin
            if (sb_q.size() == 0) chk("sb_unexpected_txw", 1, 0);
            else chk("sb_txbyte", slot_wr_data, {24'b0, sb_q.pop_front()});
        end
        last_grant = tx_ready;
        if (!reset) begin
            n_rxv = m_rxv;
            if (m_rxv && rx_ready) n_rxv = 0;
            nop = OP_READ;
            case (m_op)
                OP_NONE: nop = OP_CFG;
                OP_CFG:  m_pend = 0;
                OP_READ: begin
                    if (m_pend) nop = OP_CFG;
                    else if (srx) begin
                        nop = OP_POP; n_rxv = 1; m_rxd = status[7:0]; m_lastrx = 1;
                    end else if (stx) begin
                        nop = OP_TXW; m_wbyte = tx_data[8*g +: 8]; m_rr = (g + 1) % NREQ; m_lastrx = 0;
                    end
                end
                default: ;
            endcase
            if (cfg_wr) begin m_dvsr = cfg_dvsr; m_pend = 1; end
            m_op = nop;
            m_rxv = n_rxv;
        end
    end

    task automatic cyc(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); #1; endtask

    initial begin
        int bad, pops, n;
        int wa[$];
        repeat (3) cyc();
        smp();
        chk("rst_cs", slot_cs, 0);
        chk("rst_wdata", slot_wr_data, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_cfg_busy", cfg_busy, 0);
        cyc(); reset = 1'b0; smp();
        chk("cyc1_cs", slot_cs, 0);
        cyc(); smp();
        chk("cfg_write", slot_write, 1);
        chk("cfg_addr", slot_addr, 1);
        chk("cfg_data", slot_wr_data, 32'h0000028A);
        cyc(); smp();
        chk("poll_read", slot_read, 1);
        chk("poll_addr", slot_addr, 0);
        cyc(); smp();

        cyc(); tx_valid = 2'b01; tx_data[7:0] = 8'h55; smp();
        chk("tx0_ready", tx_ready, 2'b01);
        cyc(); tx_valid = 2'b00; smp();
        chk("tx0_addr", slot_addr, 2);
        chk("tx0_data", slot_wr_data, 32'h00000055);
        cyc(); smp();
        chk("tx0_back_poll", slot_read, 1);

        cyc(); status = 32'h300; tx_valid = 2'b10; tx_data[15:8] = 8'h3C;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            smp();
            if (tx_ready != 0 || (slot_write && slot_addr == 5'd2)) bad++;
            cyc();
        end
        chk("txfull_block", bad, 0);
        status = 32'h100; smp();
        chk("tx1_ready", tx_ready, 2'b10);
        cyc(); tx_valid = 2'b00; smp();
        chk("tx1_data", slot_wr_data, 32'h0000003C);
        cyc(); smp();

        cyc(); tx_valid = 2'b11; tx_data = 16'h2211;
        for (int k = 0; k < 8; k++) begin
            smp();
            if (k % 2 == 0) chk("rr_grant", tx_ready, ((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
            else chk("rr_data", slot_wr_data, ((k / 2) % 2 == 0) ? 32'h11 : 32'h22);
            cyc();
        end
        tx_valid = 2'b00; smp();

        cyc(); status = 32'h0A5; rx_ready = 1'b0; smp();
        cyc(); smp();
        chk("rx_valid", rx_valid, 1);
        chk("rx_data", rx_data, 8'hA5);
        chk("rx_pop_addr", slot_addr, 3);
        pops = 0;
        repeat (6) begin cyc(); smp(); if (slot_write && slot_addr == 5'd3) pops++; end
        chk("rx_no_extra_pop", pops, 0);
        cyc(); rx_ready = 1'b1; smp();
        cyc(); rx_ready = 1'b0; smp();
        chk("rx_hs_clear", rx_valid, 0);
        cyc(); smp();
        chk("rx_recapture_pop", slot_addr, 3);
        cyc(); rx_ready = 1'b1; tx_valid = 2'b01; tx_data[7:0] = 8'h77;
        for (int i = 0; i < 10; i++) begin
            smp();
            if (slot_write) wa.push_back(int'(slot_addr));
            cyc();
        end
        chk("alt_count", wa.size(), 5);
        for (int i = 0; i < 5 && i < wa.size(); i++) chk("alt_order", wa[i], (i % 2) ? 3 : 2);
        status = 32'h100; smp();

        cyc(); cfg_wr = 1'b1; cfg_dvsr = 14'h1B2; smp();
        cyc(); cfg_wr = 1'b0; smp();
        chk("cfg_busy_set", cfg_busy, 1);
        n = 0;
        while (!(slot_write && slot_addr == 5'd1) && n < 6) begin cyc(); smp(); n++; end
        chk("cfg_reload_seen", n < 6, 1);
        chk("cfg_reload_data", slot_wr_data, 32'h000001B2);
        cyc(); smp();
        chk("cfg_busy_clear", cfg_busy, 0);

        n = 0;
        cyc(); smp();
        while (!(slot_write && slot_addr == 5'd2) && n < 6) begin cyc(); smp(); n++; end
        chk("txw_before_reset", n < 6, 1);
        reset = 1'b1; #1;
        chk("async_rst_cs", slot_cs, 0);
        chk("async_rst_write", slot_write, 0);
        chk("async_rst_ready", tx_ready, 0);
        tx_valid = 2'b00;
        cyc(); cyc(); reset = 1'b0; smp();
        chk("restart_rst", slot_cs, 0);
        cyc(); smp();
        chk("restart_cfg_data", slot_wr_data, 32'h0000028A);

        for (int c = 0; c < 3000; c++) begin
            cyc();
            reset = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!tx_valid[i] || last_grant[i]) begin
                    tx_valid[i] = $urandom_range(0, 1);
                    tx_data[8*i +: 8] = 8'($urandom);
                end
            end
            status   = {22'b0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 8'($urandom)};
            rx_ready = $urandom_range(0, 1);
            cfg_wr   = ($urandom_range(0, 39) == 0);
            cfg_dvsr = 14'($urandom);
        end
        cyc(); reset = 1'b0; tx_valid = '0; cfg_wr = 1'b0;
        repeat (4) cyc();
        smp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
